// File: rtl/writeback_phase.sv
// Writeback stage: aligns/extends loads, stitches word-straddling loads from two
// consecutive memory words (one stall cycle), and drives the GPR write port.
module writeback_phase #(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int REG_W      = 64,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   ew_opcode,
  input  logic [REG_ADDR_W-1:0] ew_reg_addr_d,
  input  logic [REG_W-1:0]      ew_d,
  input  logic [2:0]            ew_ld_offset,
  input  logic [ADDR_W-1:0]     ew_mem_addr,
  input  logic [63:0]           ld_data,
  output logic                  stall,
  output logic                  wb_mem_req,
  output logic [ADDR_W-1:0]     wb_mem_addr,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [REG_W-1:0]      wb_data
);

  localparam logic [OPCODE_W-1:0] MICRO_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] MICRO_CMP  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] MICRO_CMPI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] MICRO_LB   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] MICRO_LD   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] MICRO_LQ   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] MICRO_SB   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] MICRO_SD   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] MICRO_SQ   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] MICRO_J    = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] MICRO_JE   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] MICRO_JNE  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] MICRO_JL   = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] MICRO_JG   = OPCODE_W'(15);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                  state_q, state_d;
  logic [63:0]             lo_q, lo_d;
  logic [OPCODE_W-1:0]     op_q, op_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [2:0]              off_q, off_d;
  logic                    wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [REG_W-1:0]        wb_data_q, wb_data_d;

  logic        is_writer;
  logic        is_load;
  logic        split_needed;
  logic [5:0]  lo_sh;
  logic [6:0]  hi_sh;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic [63:0] merged;

  always_comb begin
    is_writer = 1'b1;
    case (ew_opcode)
      MICRO_NOP, MICRO_SB, MICRO_SD, MICRO_SQ, MICRO_CMP, MICRO_CMPI,
      MICRO_J, MICRO_JE, MICRO_JNE, MICRO_JL, MICRO_JG: is_writer = 1'b0;
      default: ;
    endcase
    is_load      = (ew_opcode == MICRO_LB) || (ew_opcode == MICRO_LD) ||
                   (ew_opcode == MICRO_LQ);
    split_needed = ((ew_opcode == MICRO_LD) && (ew_ld_offset > 3'd4)) ||
                   ((ew_opcode == MICRO_LQ) && (ew_ld_offset != 3'd0));
    lo_sh   = {ew_ld_offset, 3'b000};
    shifted = ld_data >> lo_sh;
    case (ew_opcode)
      MICRO_LB: load_val = {56'b0, shifted[7:0]};
      MICRO_LD: load_val = {32'b0, shifted[31:0]};
      default:  load_val = shifted;
    endcase
    // off_q is never zero in SPLIT, so the high-word shift stays within 8..56.
    hi_sh  = 7'd64 - {1'b0, off_q, 3'b000};
    merged = lo_q | (ld_data << hi_sh);
  end

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    op_d        = op_q;
    rd_d        = rd_q;
    off_d       = off_q;
    wb_we_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    stall       = 1'b0;
    wb_mem_req  = 1'b0;
    wb_mem_addr = ew_mem_addr + ADDR_W'(1);
    case (state_q)
      IDLE: begin
        if (split_needed) begin
          stall      = ~rst;
          wb_mem_req = ~rst;
          lo_d       = shifted;
          op_d       = ew_opcode;
          rd_d       = ew_reg_addr_d;
          off_d      = ew_ld_offset;
          state_d    = SPLIT;
        end else begin
          wb_we_d   = is_writer;
          wb_addr_d = ew_reg_addr_d;
          wb_data_d = is_load ? REG_W'(load_val) : ew_d;
        end
      end
      SPLIT: begin
        wb_we_d   = 1'b1;
        wb_addr_d = rd_q;
        wb_data_d = (op_q == MICRO_LD) ? REG_W'({32'b0, merged[31:0]}) : REG_W'(merged);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      off_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      off_q     <= off_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_writeback_phase.sv
// Bench for writeback_phase: directed and random instructions, expected GPR
// writes (with their cycle) queued at drive time and popped when wb_we fires.
module tb_writeback_phase;

  localparam int OPCODE_W   = 6;
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 64;
  localparam int ADDR_W     = 16;
  localparam int W          = 16 + REG_ADDR_W + REG_W;

  localparam logic [5:0] OP_NOP = 6'd0,  OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_CMP = 6'd3;
  localparam logic [5:0] OP_CMPI = 6'd4, OP_LB = 6'd5,   OP_LD = 6'd6,   OP_LQ = 6'd7;
  localparam logic [5:0] OP_SB = 6'd8,   OP_SD = 6'd9,   OP_SQ = 6'd10,  OP_J = 6'd11;
  localparam logic [5:0] OP_JE = 6'd12,  OP_JNE = 6'd13, OP_JL = 6'd14,  OP_JG = 6'd15;
  localparam logic [5:0] OP_MOVI = 6'd16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [OPCODE_W-1:0]   ew_opcode = '0;
  logic [REG_ADDR_W-1:0] ew_reg_addr_d = '0;
  logic [REG_W-1:0]      ew_d = '0;
  logic [2:0]            ew_ld_offset = '0;
  logic [ADDR_W-1:0]     ew_mem_addr = '0;
  logic [63:0]           ld_data = '0;
  logic                  stall, wb_mem_req, wb_we;
  logic [ADDR_W-1:0]     wb_mem_addr;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [REG_W-1:0]      wb_data;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cyc = '0;
  logic [W-1:0] exp_q[$];

  writeback_phase #(
    .OPCODE_W(OPCODE_W), .REG_ADDR_W(REG_ADDR_W), .REG_W(REG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .ew_opcode(ew_opcode), .ew_reg_addr_d(ew_reg_addr_d),
    .ew_d(ew_d), .ew_ld_offset(ew_ld_offset), .ew_mem_addr(ew_mem_addr),
    .ld_data(ld_data), .stall(stall), .wb_mem_req(wb_mem_req),
    .wb_mem_addr(wb_mem_addr), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_writer(input logic [5:0] op);
    case (op)
      OP_NOP, OP_SB, OP_SD, OP_SQ, OP_CMP, OP_CMPI,
      OP_J, OP_JE, OP_JNE, OP_JL, OP_JG: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_split(input logic [5:0] op, input logic [2:0] off);
    return ((op == OP_LD) && (off > 3'd4)) || ((op == OP_LQ) && (off != 3'd0));
  endfunction

  function automatic logic [63:0] model_data(input logic [5:0] op, input logic [63:0] d,
                                             input logic [2:0] off, input logic [63:0] ld0,
                                             input logic [63:0] ld1);
    logic [127:0] pair;
    pair = {ld1, ld0} >> (8 * off);
    case (op)
      OP_LB:   return {56'b0, pair[7:0]};
      OP_LD:   return {32'b0, pair[31:0]};
      OP_LQ:   return pair[63:0];
      default: return d;
    endcase
  endfunction

  // Presents one instruction; for a split load also supplies the second word.
  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [63:0] d,
                       input logic [2:0] off, input logic [15:0] maddr,
                       input logic [63:0] ld0, input logic [63:0] ld1);
    logic        sp;
    logic [15:0] nxt;
    logic [15:0] c;
    @(posedge clk);
    #1;
    c  = cyc;
    sp = model_split(op, off);
    nxt = maddr + 16'd1;
    ew_opcode = op; ew_reg_addr_d = rd; ew_d = d;
    ew_ld_offset = off; ew_mem_addr = maddr; ld_data = ld0;
    if (model_writer(op))
      exp_q.push_back({c + (sp ? 16'd2 : 16'd1), rd, model_data(op, d, off, ld0, ld1)});
    #1;
    check("stall", {63'b0, stall}, {63'b0, sp});
    check("mem_req", {63'b0, wb_mem_req}, {63'b0, sp});
    if (sp) begin
      check("mem_addr", {48'b0, wb_mem_addr}, {48'b0, nxt});
      @(posedge clk);
      #1;
      ld_data = ld1;
      #1;
      check("split_stall", {63'b0, stall}, 64'd0);
      check("split_req", {63'b0, wb_mem_req}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wb_cycle", {48'b0, cyc}, {48'b0, e[W-1 -: 16]});
        check("wb_addr", {59'b0, wb_addr}, {59'b0, e[REG_W +: REG_ADDR_W]});
        check("wb_data", wb_data, e[REG_W-1:0]);
      end
    end
  end

  localparam logic [63:0] W0 = 64'h8877665544332211;
  localparam logic [63:0] W1 = 64'hFFEEDDCCBBAA9988;

  initial begin
    logic [5:0] ops [15];
    ops = '{OP_ADD, OP_SUB, OP_MOVI, OP_LB, OP_LD, OP_LQ, OP_LD, OP_LQ,
            OP_NOP, OP_SB, OP_SD, OP_SQ, OP_JE, OP_CMP, OP_CMPI};

    // Reset with a split-type load on the inputs: outputs must stay quiet.
    rst = 1'b1;
    ew_opcode = OP_LQ; ew_ld_offset = 3'd3; ew_reg_addr_d = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", {63'b0, stall}, 64'd0);
    check("rst_req", {63'b0, wb_mem_req}, 64'd0);
    check("rst_we", {63'b0, wb_we}, 64'd0);
    check("rst_addr", {59'b0, wb_addr}, 64'd0);
    check("rst_data", wb_data, 64'd0);
    ew_opcode = OP_NOP;
    rst = 1'b0;

    drive(OP_ADD, 5'd3, 64'h1234, 3'd0, 16'h0, W0, W1);
    drive(OP_LB, 5'd4, 64'hDEAD, 3'd5, 16'h8, W0, W1);
    drive(OP_LD, 5'd5, 64'h0, 3'd4, 16'h8, W0, W1);
    drive(OP_LD, 5'd6, 64'h0, 3'd6, 16'h10, W0, W1);
    drive(OP_LQ, 5'd7, 64'h0, 3'd3, 16'hFFFF, W0, W1);
    drive(OP_SQ, 5'd8, 64'h55, 3'd0, 16'h2, W0, W1);
    drive(OP_JE, 5'd9, 64'h66, 3'd0, 16'h2, W0, W1);
    drive(OP_CMP, 5'd10, 64'h77, 3'd0, 16'h2, W0, W1);
    drive(OP_ADD, 5'd0, 64'hABCD, 3'd0, 16'h0, W0, W1);
    drive(OP_LQ, 5'd11, 64'h0, 3'd0, 16'h4, W0, W1);
    drive(OP_LQ, 5'd12, 64'h0, 3'd7, 16'h20, W1, W0);
    drive(OP_LD, 5'd13, 64'h0, 3'd5, 16'h21, W0, W1);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] ma;
      ma = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      drive(ops[$urandom_range(0, 14)], 5'($urandom_range(0, 31)), {$urandom, $urandom},
            3'($urandom_range(0, 7)), ma, {$urandom, $urandom}, {$urandom, $urandom});
    end

    // Reset while in SPLIT: the pending write must be dropped.
    @(posedge clk);
    #1;
    ew_opcode = OP_LD; ew_reg_addr_d = 5'd14; ew_ld_offset = 3'd7;
    ew_mem_addr = 16'h30; ld_data = W0;
    #1;
    check("pre_rst_stall", {63'b0, stall}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ld_data = W1;
    #1;
    check("split_rst_stall", {63'b0, stall}, 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_we", {63'b0, wb_we}, 64'd0);
    check("post_rst_stall", {63'b0, stall}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ew_opcode = OP_NOP;
    #1;
    check("idle_stall", {63'b0, stall}, 64'd0);
    check("idle_we", {63'b0, wb_we}, 64'd0);

    drive(OP_ADD, 5'd15, 64'h4242, 3'd0, 16'h0, W0, W1);
    drive(OP_NOP, 5'd0, 64'h0, 3'd0, 16'h0, W0, W1);
    repeat (4) @(posedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_phase.md
# writeback_phase

Final pipeline stage, directly downstream of the execute stage. Consumes the execute-to-writeback register bundle (`ew_*`) and the data-memory read word, and drives the GPR write port. Aligns and extends byte, dword and qword loads. For loads that straddle an 8-byte memory word, it issues a second read and stalls the pipeline for exactly one cycle.

## Interface
- `OPCODE_W`, default from `common_params.h`: micro-opcode width.
- `REG_ADDR_W`, default from `common_params.h`: GPR index width.
- `REG_W`, default 64: register width.
- `ADDR_W`, default from `common_params.h`: memory word-address width (8-byte words).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ew_opcode` in OPCODE_W: micro-opcode of the instruction in writeback.
- `ew_reg_addr_d` in REG_ADDR_W: destination GPR.
- `ew_d` in REG_W: ALU result.
- `ew_ld_offset` in 3: byte offset of the load within its word.
- `ew_mem_addr` in ADDR_W: word address read for this instruction.
- `ld_data` in 64: read data for the address presented in the previous cycle. Little-endian: byte k is `ld_data[8k+7:8k]`.
- `stall` out 1: holds the upstream stages and `ew_*` stable.
- `wb_mem_req` out 1: selects `wb_mem_addr` onto the data-memory address port.
- `wb_mem_addr` out ADDR_W: second-read word address.
- `wb_we` out 1: GPR write enable.
- `wb_addr` out REG_ADDR_W: GPR write index.
- `wb_data` out REG_W: GPR write data.

## Operation
- **Writers:** every opcode except `MICRO_NOP`, `MICRO_SB`, `MICRO_SD`, `MICRO_SQ`, all `MICRO_J*`, `MICRO_CMP` and `MICRO_CMPI`. Non-writers produce `wb_we=0`.
- **Non-load writer:** `wb_data = ew_d`.
- **`MICRO_LB`:** byte `off`, zero-extended to 64 bits. Never splits.
- **`MICRO_LD`:** 4 bytes starting at `off`, zero-extended. Splits when `off>4`.
- **`MICRO_LQ`:** 8 bytes starting at `off`. Splits when `off!=0`.
- **FSM states:** IDLE and SPLIT.
- **IDLE, split needed:**
  - Assert `stall=1` and `wb_mem_req=1`.
  - Drive `wb_mem_addr = ew_mem_addr+1`, wrapping modulo 2^ADDR_W.
  - Latch `lo = ld_data >> 8*off`, plus the opcode, `ew_reg_addr_d` and `off`.
  - Issue no write; go to SPLIT.
- **IDLE, otherwise:** register the write result; stay in IDLE.
- **SPLIT:**
  - Ignore `ew_*`; they are still the held load.
  - `merged = lo | (ld_data << 8*(8-off))`, kept to 64 bits.
  - For `MICRO_LD`, zero-extend `merged[31:0]`.
  - Register the write; go to IDLE.
- `stall` and `wb_mem_req` are combinational: asserted only when in IDLE, a split is needed, and `rst=0`.

## Timing
- **Reset:** state=IDLE, `wb_we=0`, `wb_addr=0`, `wb_data=0`, latches cleared. `stall=0` and `wb_mem_req=0` whenever `rst=1`.
- **Non-split:** `ew_*` in cycle N gives `wb_*` valid in cycle N+1, for one cycle.
- **Split:**
  - Cycle N: `stall=1`, second address issued.
  - Cycle N+1: SPLIT state, `ld_data` holds the next word, `stall=0`.
  - Cycle N+2: `wb_we=1`.
  - Exactly one stall cycle per split load.
- **Back-to-back:** a new instruction is accepted in the cycle after SPLIT. No bubble other than the stall.
- **`rst` in SPLIT:** return to IDLE, no write, `stall=0` from the next cycle.
- `wb_we` is pulsed for one cycle per writer instruction, including when `ew_reg_addr_d=0`.

## Test plan
- **ALU writer:** `MICRO_ADD`, reg 3, `ew_d=0x1234` → next cycle `wb_we=1`, `wb_addr=3`, `wb_data=0x1234`, `stall=0`.
- **`MICRO_LB`:** `off=5`, `ld_data=0x8877665544332211` → `wb_data=0x66`.
- **`MICRO_LD`, no split:** `off=4` → `0x88776655`, no stall.
- **`MICRO_LD`, split:** `off=6`, `ew_mem_addr=0x10`, then `ld_data=0xFFEEDDCCBBAA9988` → one stall cycle, `wb_mem_addr=0x11`, `wb_data=0x99888877` two cycles after accept.
- **`MICRO_LQ`, split with wrap:** `off=3`, `ew_mem_addr` = all ones, same two words → `wb_mem_addr=0`, `wb_data=0xAA99888877665544`.
- **Non-writers and reset:** `MICRO_SQ`, `MICRO_JE` and `MICRO_CMP` each give `wb_we=0`. `rst` asserted during SPLIT gives no write; `wb_we=0`, `stall=0` after reset.
